// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic phase controller.
package traffic_pkg;

  // Phase encodings as seen on the phase output.
  typedef enum logic [1:0] {
    PhGreen  = 2'd0,
    PhYellow = 2'd1,
    PhAllred = 2'd2,
    PhEmerg  = 2'd3
  } phase_t;

  // Lamp triple {green, yellow, red} for one approach, given the phase and
  // whether that approach currently owns the phase.
  function automatic logic [2:0] lamp_decode(phase_t ph, logic is_active);
    logic [2:0] lamp;
    lamp = 3'b001;
    if (is_active) begin
      case (ph)
        PhGreen, PhEmerg: lamp = 3'b100;
        PhYellow:         lamp = 3'b010;
        default:          lamp = 3'b001;
      endcase
    end
    return lamp;
  endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Combinational round-robin picker: first set bit of pending after active_dir,
// excluding active_dir itself. Falls back to active_dir+1 when none is set.
module rr_next_dir #(
  parameter int unsigned NUM_DIRS = 4,
  localparam int unsigned DW = $clog2(NUM_DIRS)
) (
  input  logic [NUM_DIRS-1:0] pending,
  input  logic [DW-1:0]       active_dir,
  output logic [DW-1:0]       next_dir,
  output logic                any_valid
);

  logic [DW-1:0] idx;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    next_dir  = DW'((int'(active_dir) + 1) % int'(NUM_DIRS));
    any_valid = 1'b0;
    idx       = '0;
    for (int k = int'(NUM_DIRS) - 1; k > 0; k--) begin
      idx = DW'((int'(active_dir) + k) % int'(NUM_DIRS));
      if (pending[idx]) begin
        next_dir  = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-direction traffic phase controller: green -> yellow -> all-red rotation,
// optional demand skipping, and emergency pre-emption.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIRS    = 4,
  parameter int unsigned GREEN_CYC   = 6000,
  parameter int unsigned YELLOW_CYC  = 500,
  parameter int unsigned ALLRED_CYC  = 100,
  parameter bit          DEMAND_MODE = 1'b0,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned DW = $clog2(NUM_DIRS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_DIRS-1:0] req,
  input  logic                emerg,
  input  logic [DW-1:0]       emerg_dir,
  output logic [NUM_DIRS-1:0] green,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] red,
  output logic [DW-1:0]       active_dir,
  output logic [1:0]          phase
);

  localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AllredLast = CNT_W'(ALLRED_CYC - 1);

  phase_t              phase_q, phase_d;
  logic [DW-1:0]       dir_q, dir_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [NUM_DIRS-1:0] pend_q, pend_d;
  logic                elat_q, elat_d;
  logic [DW-1:0]       edir_q, edir_d;
  logic [NUM_DIRS-1:0] green_q, yellow_q, red_q;
  logic [NUM_DIRS-1:0] green_d, yellow_d, red_d;

  logic [NUM_DIRS-1:0] pend_sel;
  logic [DW-1:0]       next_dir;
  logic                any_valid;
  logic                em_seen;
  logic [DW-1:0]       em_tgt;
  logic                clear_done;
  logic [2:0]          lamp;

  // Fixed rotation treats every approach as pending, so the picker yields dir+1.
  assign pend_sel = DEMAND_MODE ? pend_q : '1;

  rr_next_dir #(
    .NUM_DIRS(NUM_DIRS)
  ) u_rr (
    .pending   (pend_sel),
    .active_dir(dir_q),
    .next_dir  (next_dir),
    .any_valid (any_valid)
  );

  // Next-state: phase sequencing, timer, request and emergency latches.
  always_comb begin
    phase_d    = phase_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    elat_d     = elat_q;
    edir_d     = edir_q;
    pend_d     = pend_q | req;
    em_seen    = elat_q | emerg;
    em_tgt     = elat_q ? edir_q : emerg_dir;
    clear_done = 1'b0;

    // emerg_dir is only captured on the first cycle emerg is seen.
    if (emerg && !elat_q) begin
      elat_d = 1'b1;
      edir_d = emerg_dir;
    end

    unique case (phase_q)
      PhGreen: begin
        if (em_seen) begin
          if (dir_q == em_tgt) begin
            phase_d = PhEmerg;
          end else begin
            phase_d = PhYellow;
            timer_d = '0;
          end
        end else if (timer_q != GreenLast) begin
          timer_d = timer_q + CNT_W'(1);
        end else if (!DEMAND_MODE || any_valid) begin
          phase_d = PhYellow;
          timer_d = '0;
        end
      end
      PhYellow: begin
        if (timer_q != YellowLast) begin
          timer_d = timer_q + CNT_W'(1);
        end else if (ALLRED_CYC == 0) begin
          clear_done = 1'b1;
        end else begin
          phase_d = PhAllred;
          timer_d = '0;
        end
      end
      PhAllred: begin
        if (timer_q != AllredLast) begin
          timer_d = timer_q + CNT_W'(1);
        end else begin
          clear_done = 1'b1;
        end
      end
      PhEmerg: begin
        if (!emerg) begin
          phase_d = PhYellow;
          dir_d   = edir_q;
          timer_d = '0;
          elat_d  = 1'b0;
        end
      end
    endcase

    // End of clearance: either hand over to the emergency approach or the next green.
    if (clear_done) begin
      timer_d = '0;
      if (em_seen) begin
        phase_d = PhEmerg;
        dir_d   = em_tgt;
      end else begin
        phase_d          = PhGreen;
        dir_d            = next_dir;
        pend_d[next_dir] = 1'b0;
      end
    end
  end

  // Lamp outputs decoded from the next state so the registered lamps track phase_q.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '0;
    lamp     = '0;
    for (int d = 0; d < int'(NUM_DIRS); d++) begin
      lamp        = lamp_decode(phase_d, dir_d == DW'(d));
      green_d[d]  = lamp[2];
      yellow_d[d] = lamp[1];
      red_d[d]    = lamp[0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PhGreen;
      dir_q    <= '0;
      timer_q  <= '0;
      pend_q   <= '0;
      elat_q   <= 1'b0;
      edir_q   <= '0;
      green_q  <= NUM_DIRS'(1);
      yellow_q <= '0;
      red_q    <= {{(NUM_DIRS - 1){1'b1}}, 1'b0};
    end else begin
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      elat_q   <= elat_d;
      edir_q   <= edir_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
    end
  end

  assign green      = green_q;
  assign yellow     = yellow_q;
  assign red        = red_q;
  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: three configurations driven with random requests and
// emergencies, compared every cycle against a cycle-level reference model.
module tb_traffic_phase_ctrl;

  typedef struct {
    int n;
    int g;
    int y;
    int a;
    bit dm;
  } cfg_t;

  typedef struct {
    int       ph;    // 0 green, 1 yellow, 2 all-red, 3 emergency
    int       dir;
    int       el;    // cycles already spent in the current phase
    bit [7:0] pend;
    bit       elat;
    int       edir;
  } mst_t;

  logic clk = 1'b0;
  logic rst;

  logic [3:0] req_a;  logic emerg_a;  logic [1:0] edir_a;
  logic [3:0] g_a, y_a, r_a;  logic [1:0] ad_a, ph_a;
  logic [2:0] req_b;  logic emerg_b;  logic [1:0] edir_b;
  logic [2:0] g_b, y_b, r_b;  logic [1:0] ad_b, ph_b;
  logic [1:0] req_c;  logic emerg_c;  logic [0:0] edir_c;
  logic [1:0] g_c, y_c, r_c;  logic [0:0] ad_c;  logic [1:0] ph_c;

  cfg_t ca, cb, cc;
  mst_t ma, mb, mc;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .NUM_DIRS(4), .GREEN_CYC(6000), .YELLOW_CYC(500), .ALLRED_CYC(100),
    .DEMAND_MODE(1'b0), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .emerg(emerg_a), .emerg_dir(edir_a),
    .green(g_a), .yellow(y_a), .red(r_a), .active_dir(ad_a), .phase(ph_a)
  );

  traffic_phase_ctrl #(
    .NUM_DIRS(3), .GREEN_CYC(20), .YELLOW_CYC(4), .ALLRED_CYC(2),
    .DEMAND_MODE(1'b1), .CNT_W(8)
  ) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .emerg(emerg_b), .emerg_dir(edir_b),
    .green(g_b), .yellow(y_b), .red(r_b), .active_dir(ad_b), .phase(ph_b)
  );

  traffic_phase_ctrl #(
    .NUM_DIRS(2), .GREEN_CYC(12), .YELLOW_CYC(3), .ALLRED_CYC(0),
    .DEMAND_MODE(1'b0), .CNT_W(4)
  ) u_dut_c (
    .clk(clk), .rst(rst), .req(req_c), .emerg(emerg_c), .emerg_dir(edir_c),
    .green(g_c), .yellow(y_c), .red(r_c), .active_dir(ad_c), .phase(ph_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mst_t mreset();
    mst_t s;
    s.ph = 0; s.dir = 0; s.el = 0; s.pend = '0; s.elat = 1'b0; s.edir = 0;
    return s;
  endfunction

  // First pending approach after dir in round-robin order (everything counts as
  // pending in fixed rotation); -1 when there is none.
  function automatic int pick(cfg_t c, mst_t s);
    for (int k = 1; k < c.n; k++) begin
      int d;
      d = (s.dir + k) % c.n;
      if (!c.dm || s.pend[d]) return d;
    end
    return -1;
  endfunction

  function automatic mst_t mstep(cfg_t c, mst_t s, logic [7:0] rq, logic em, int ed);
    mst_t t;
    bit   seen;
    int   tgt;
    bit   done;
    int   nd;
    t    = s;
    seen = s.elat || em;
    tgt  = s.elat ? s.edir : ed;
    done = 1'b0;
    if (em && !s.elat) begin
      t.elat = 1'b1;
      t.edir = ed;
    end
    t.pend = s.pend | rq;
    case (s.ph)
      0: begin
        if (seen) begin
          if (s.dir == tgt) t.ph = 3;
          else begin t.ph = 1; t.el = 0; end
        end else if (s.el < c.g - 1) t.el = s.el + 1;
        else if (!c.dm || pick(c, s) >= 0) begin t.ph = 1; t.el = 0; end
      end
      1: begin
        if (s.el < c.y - 1) t.el = s.el + 1;
        else if (c.a == 0) done = 1'b1;
        else begin t.ph = 2; t.el = 0; end
      end
      2: begin
        if (s.el < c.a - 1) t.el = s.el + 1;
        else done = 1'b1;
      end
      default: begin
        if (!em) begin
          t.ph = 1; t.dir = s.edir; t.el = 0; t.elat = 1'b0;
        end
      end
    endcase
    if (done) begin
      t.el = 0;
      if (seen) begin
        t.ph  = 3;
        t.dir = tgt;
      end else begin
        nd = pick(c, s);
        if (nd < 0) nd = (s.dir + 1) % c.n;
        t.ph = 0;
        t.dir = nd;
        t.pend[nd] = 1'b0;
      end
    end
    return t;
  endfunction

  task automatic cmp(input string tag, input cfg_t c, input mst_t s, input logic [7:0] g,
                     input logic [7:0] y, input logic [7:0] r, input logic [2:0] ad,
                     input logic [1:0] ph);
    logic [7:0] eg, ey, er;
    bit         ok;
    int         nonred;
    eg = '0; ey = '0; er = '0; ok = 1'b1; nonred = 0;
    for (int d = 0; d < c.n; d++) begin
      eg[d] = (s.ph == 0 || s.ph == 3) && s.dir == d;
      ey[d] = (s.ph == 1) && s.dir == d;
      er[d] = !(eg[d] || ey[d]);
      if ($countones({g[d], y[d], r[d]}) != 1) ok = 1'b0;
      if (r[d] !== 1'b1) nonred++;
    end
    check({tag, "_green"}, 32'(g), 32'(eg));
    check({tag, "_yellow"}, 32'(y), 32'(ey));
    check({tag, "_red"}, 32'(r), 32'(er));
    check({tag, "_dir"}, 32'(ad), 32'(s.dir));
    check({tag, "_phase"}, 32'(ph), 32'(s.ph));
    check({tag, "_lamp_onehot"}, 32'(ok), 32'(1));
    check({tag, "_one_nonred"}, 32'(nonred <= 1), 32'(1));
  endtask

  task automatic compare_all();
    cmp("a", ca, ma, 8'(g_a), 8'(y_a), 8'(r_a), 3'(ad_a), ph_a);
    cmp("b", cb, mb, 8'(g_b), 8'(y_b), 8'(r_b), 3'(ad_b), ph_b);
    cmp("c", cc, mc, 8'(g_c), 8'(y_c), 8'(r_c), 3'(ad_c), ph_c);
  endtask

  task automatic step_all();
    @(posedge clk);
    #1;
    ma = mstep(ca, ma, 8'(req_a), emerg_a, int'(edir_a));
    mb = mstep(cb, mb, 8'(req_b), emerg_b, int'(edir_b));
    mc = mstep(cc, mc, 8'(req_c), emerg_c, int'(edir_c));
    compare_all();
  endtask

  task automatic model_reset();
    ma = mreset(); mb = mreset(); mc = mreset();
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_green"}, 32'(g_a), 32'(4'b0001));
    check({tag, "_yellow"}, 32'(y_a), 32'(4'b0000));
    check({tag, "_red"}, 32'(r_a), 32'(4'b1110));
    check({tag, "_phase"}, 32'(ph_a), 32'(0));
    check({tag, "_dir"}, 32'(ad_a), 32'(0));
  endtask

  initial begin
    int stage;
    int hold;
    ca = '{n: 4, g: 6000, y: 500, a: 100, dm: 1'b0};
    cb = '{n: 3, g: 20, y: 4, a: 2, dm: 1'b1};
    cc = '{n: 2, g: 12, y: 3, a: 0, dm: 1'b0};
    rst = 1'b0;
    req_a = '0; emerg_a = 1'b0; edir_a = '0;
    req_b = '0; emerg_b = 1'b0; edir_b = '0;
    req_c = '0; emerg_c = 1'b0; edir_c = '0;
    model_reset();
    stage = 0;
    hold  = 0;

    #23;
    check_a_reset("reset_a");
    compare_all();
    #4 rst = 1'b1;

    for (int cyc = 0; cyc < 50000 && errors < 50; cyc++) begin
      // Approach-set A: clean rotations, two directed emergencies, then random ones.
      case (stage)
        0: if (cyc >= 26500) stage = 1;
        1: if (ma.ph == 0 && ma.dir == 0 && ma.el == 1000) begin
          emerg_a = 1'b1; edir_a = 2'd3; hold = 800; stage = 2;
        end
        2: if (hold == 0) begin emerg_a = 1'b0; stage = 3; end else hold--;
        3: if (ma.ph == 0 && ma.el == 50) begin
          emerg_a = 1'b1; edir_a = 2'(ma.dir); hold = 100; stage = 4;
        end
        4: if (hold == 0) begin emerg_a = 1'b0; stage = 5; end else hold--;
        default: begin
          if (!emerg_a) begin
            if ($urandom_range(799, 0) == 0) begin
              emerg_a = 1'b1; edir_a = 2'($urandom_range(3, 0));
            end
          end else if ($urandom_range(199, 0) == 0) emerg_a = 1'b0;
        end
      endcase
      req_a = 4'($urandom);

      // Demand-mode set B: request bursts with quiet windows, rare emergencies.
      if ((cyc / 500) % 2 == 0 && $urandom_range(39, 0) == 0)
        req_b = 3'(1 << $urandom_range(2, 0));
      else
        req_b = '0;
      if (!emerg_b) emerg_b = ($urandom_range(149, 0) == 0);
      else if ($urandom_range(11, 0) == 0) emerg_b = 1'b0;
      edir_b = 2'($urandom_range(2, 0));

      // Two-way set C with no clearance phase.
      req_c = 2'($urandom);
      if (!emerg_c) emerg_c = ($urandom_range(99, 0) == 0);
      else if ($urandom_range(9, 0) == 0) emerg_c = 1'b0;
      edir_c = 1'($urandom);

      step_all();
    end

    // Bring A to yellow, then pulse reset between clock edges.
    emerg_a = 1'b0; emerg_b = 1'b0; emerg_c = 1'b0;
    for (int w = 0; w < 10000 && ma.ph != 1; w++) step_all();
    check("a_reached_yellow", 32'(ma.ph), 32'(1));
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_a_reset("async_rst_a");
    compare_all();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    for (int cyc = 0; cyc < 300; cyc++) begin
      req_a = 4'($urandom);
      req_b = ($urandom_range(9, 0) == 0) ? 3'($urandom) : 3'b000;
      req_c = 2'($urandom);
      step_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
